// File: rtl/puzzle_path_checker.sv
// Recovers the move between successive 40-bit boards, checks legality, emits one move code per step.
// Latency: 1 cycle from board transfer to mv_valid; in_ready is low while a move waits on mv_ready.
module puzzle_path_checker #(
    parameter int          CNT_W = 6,
    parameter logic [39:0] GOAL  = 40'h8_123456780
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             goal_sel,
    input  logic [39:0]      goal_in,
    input  logic             in_valid,
    input  logic [39:0]      in_board,
    output logic             in_ready,
    output logic             mv_valid,
    output logic [1:0]       mv_code,
    input  logic             mv_ready,
    output logic [CNT_W-1:0] move_count,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ORIGIN,
        S_RUN,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] MV_UP    = 2'b00;
    localparam logic [1:0] MV_DOWN  = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_RIGHT = 2'b11;

    localparam logic [2:0] E_BLANK = 3'd1;
    localparam logic [2:0] E_ADJ   = 3'd2;
    localparam logic [2:0] E_TILE  = 3'd3;
    localparam logic [2:0] E_OVF   = 3'd4;

    state_t      state;
    logic [39:0] prev;
    logic [39:0] goal_r;

    logic [3:0]  p;
    logic [3:0]  q;
    logic [1:0]  p_col;
    logic        xfer;
    logic        dec_ok;
    logic [1:0]  dec_code;
    logic [2:0]  dec_err;
    logic        tiles_ok;

    function automatic logic [3:0] get_cell(input logic [39:0] b, input logic [3:0] idx);
        logic [3:0] c;
        case (idx)
            4'd0:    c = b[35:32];
            4'd1:    c = b[31:28];
            4'd2:    c = b[27:24];
            4'd3:    c = b[23:20];
            4'd4:    c = b[19:16];
            4'd5:    c = b[15:12];
            4'd6:    c = b[11:8];
            4'd7:    c = b[7:4];
            4'd8:    c = b[3:0];
            default: c = 4'd0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] pos);
        logic [1:0] c;
        case (pos)
            4'd0, 4'd3, 4'd6: c = 2'd0;
            4'd1, 4'd4, 4'd7: c = 2'd1;
            default:          c = 2'd2;
        endcase
        return c;
    endfunction

    assign in_ready = (state == S_ORIGIN) || (state == S_RUN);
    assign xfer     = in_valid && in_ready;
    assign p        = prev[39:36];
    assign q        = in_board[39:36];
    assign p_col    = col_of(p);

    // Row wraps (2->3, 5->6) fall through to the non-adjacent code via the column guards.
    always_comb begin
        dec_ok   = 1'b0;
        dec_code = MV_UP;
        dec_err  = E_ADJ;
        if (q > 4'd8) begin
            dec_err = E_BLANK;
        end else if ((p >= 4'd3) && (q == p - 4'd3)) begin
            dec_ok   = 1'b1;
            dec_code = MV_UP;
        end else if ((p <= 4'd5) && (q == p + 4'd3)) begin
            dec_ok   = 1'b1;
            dec_code = MV_DOWN;
        end else if ((p_col != 2'd0) && (q == p - 4'd1)) begin
            dec_ok   = 1'b1;
            dec_code = MV_LEFT;
        end else if ((p_col != 2'd2) && (q == p + 4'd1)) begin
            dec_ok   = 1'b1;
            dec_code = MV_RIGHT;
        end
    end

    // The two swapped cells must exchange contents; all others must be untouched.
    always_comb begin
        logic [3:0] want;
        tiles_ok = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (4'(k) == q)
                want = get_cell(prev, p);
            else if (4'(k) == p)
                want = get_cell(prev, q);
            else
                want = get_cell(prev, 4'(k));
            if (get_cell(in_board, 4'(k)) != want)
                tiles_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prev       <= '0;
            goal_r     <= GOAL;
            mv_valid   <= 1'b0;
            mv_code    <= 2'b00;
            move_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 3'd0;
        end else if (start) begin
            state      <= S_ORIGIN;
            goal_r     <= goal_sel ? goal_in : GOAL;
            mv_valid   <= 1'b0;
            move_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 3'd0;
        end else begin
            case (state)
                S_ORIGIN: begin
                    if (xfer) begin
                        if (q > 4'd8) begin
                            error    <= 1'b1;
                            err_code <= E_BLANK;
                            state    <= S_ERR;
                        end else begin
                            prev <= in_board;
                            if (in_board == goal_r) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_RUN;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (!dec_ok) begin
                            error    <= 1'b1;
                            err_code <= dec_err;
                            state    <= S_ERR;
                        end else if (!tiles_ok) begin
                            error    <= 1'b1;
                            err_code <= E_TILE;
                            state    <= S_ERR;
                        end else if (move_count == {CNT_W{1'b1}}) begin
                            error    <= 1'b1;
                            err_code <= E_OVF;
                            state    <= S_ERR;
                        end else begin
                            mv_valid   <= 1'b1;
                            mv_code    <= dec_code;
                            move_count <= move_count + CNT_W'(1);
                            prev       <= in_board;
                            state      <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (mv_ready) begin
                        mv_valid <= 1'b0;
                        if (prev == goal_r) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puzzle_path_checker.sv
// Scoreboarded bench for puzzle_path_checker: directed paths, expected moves queued at issue time.
module tb_puzzle_path_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        goal_sel;
    logic [39:0] goal_in;
    logic        in_valid;
    logic [39:0] in_board;
    logic        in_ready;
    logic        mv_valid;
    logic [1:0]  mv_code;
    logic        mv_ready;
    logic [1:0]  move_count;
    logic        done;
    logic        error;
    logic [2:0]  err_code;

    int total;
    int passed;

    logic [1:0] exp_code_q[$];
    logic [1:0] exp_cnt_q[$];

    puzzle_path_checker #(
        .CNT_W(2),
        .GOAL (40'h8_123456780)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .goal_sel  (goal_sel),
        .goal_in   (goal_in),
        .in_valid  (in_valid),
        .in_board  (in_board),
        .in_ready  (in_ready),
        .mv_valid  (mv_valid),
        .mv_code   (mv_code),
        .mv_ready  (mv_ready),
        .move_count(move_count),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: each move handshake is compared against the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && mv_valid && mv_ready) begin
            if (exp_code_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_move: got code %0h count %0h expected none", mv_code, move_count);
            end else begin
                chk("mv_code", {38'd0, mv_code}, {38'd0, exp_code_q.pop_front()});
                chk("mv_count", {38'd0, move_count}, {38'd0, exp_cnt_q.pop_front()});
            end
        end
    end

    task automatic expect_move(input logic [1:0] code, input logic [1:0] cnt);
        exp_code_q.push_back(code);
        exp_cnt_q.push_back(cnt);
    endtask

    task automatic start_path(input logic sel, input logic [39:0] g);
        start    = 1'b1;
        goal_sel = sel;
        goal_in  = g;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [39:0] b);
        bit sent;
        sent     = 1'b0;
        in_valid = 1'b1;
        in_board = b;
        for (int i = 0; i < 50 && !sent; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                sent = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!sent) begin
            total++;
            $display("FAIL send_timeout: got no in_ready expected transfer of %0h", b);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        goal_sel = 1'b0;
        goal_in  = '0;
        in_valid = 1'b0;
        in_board = '0;
        mv_ready = 1'b1;

        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mv_valid", mv_valid, 0);
        chk("rst_mv_code", mv_code, 0);
        chk("rst_move_count", move_count, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        rst_n = 1'b1;
        idle_cycles(2);
        chk("idle_in_ready", in_ready, 0);

        // 1: single RIGHT to goal
        start_path(1'b0, 40'h0);
        chk("t1_origin_ready", in_ready, 1);
        send(40'h7_123456708);
        expect_move(2'b11, 2'd1);
        send(40'h8_123456780);
        chk("t1_mv_valid", mv_valid, 1);
        chk("t1_emit_ready", in_ready, 0);
        idle_cycles(1);
        chk("t1_done", done, 1);
        chk("t1_mv_drop", mv_valid, 0);
        chk("t1_count", move_count, 1);
        chk("t1_error", error, 0);
        idle_cycles(2);
        chk("t1_done_ready", in_ready, 0);

        // 2: DOWN held under backpressure
        start_path(1'b0, 40'h0);
        chk("t2_done_clr", done, 0);
        mv_ready = 1'b0;
        send(40'h5_123450786);
        expect_move(2'b01, 2'd1);
        send(40'h8_123456780);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", mv_valid, 1);
            chk("t2_hold_code", mv_code, 2'b01);
            chk("t2_hold_ready", in_ready, 0);
            idle_cycles(1);
        end
        mv_ready = 1'b1;
        idle_cycles(1);
        chk("t2_done", done, 1);
        chk("t2_mv_drop", mv_valid, 0);

        // 3: row wrap 2->3
        start_path(1'b0, 40'h0);
        send(40'h2_120345678);
        send(40'h3_124035678);
        chk("t3_error", error, 1);
        chk("t3_err_code", err_code, 2);
        chk("t3_mv_valid", mv_valid, 0);
        idle_cycles(3);
        chk("t3_ready_low", in_ready, 0);
        chk("t3_err_sticky", error, 1);
        chk("t3_not_done", done, 0);

        // 4: tile mismatch
        start_path(1'b0, 40'h0);
        send(40'h7_123456708);
        send(40'h8_123456870);
        chk("t4_error", error, 1);
        chk("t4_err_code", err_code, 3);
        chk("t4_count", move_count, 0);

        // 5: bad blank on origin, then recovery by start
        start_path(1'b0, 40'h0);
        send(40'h9_123456780);
        chk("t5_error", error, 1);
        chk("t5_err_code", err_code, 1);
        start_path(1'b0, 40'h0);
        chk("t5_err_clr", error, 0);
        chk("t5_code_clr", err_code, 0);
        chk("t5_origin_ready", in_ready, 1);
        send(40'h7_123456708);
        expect_move(2'b11, 2'd1);
        send(40'h8_123456780);
        idle_cycles(1);
        chk("t5_done", done, 1);
        chk("t5_count", move_count, 1);

        // 6: counter saturation with an unreachable goal
        start_path(1'b1, 40'h0_012345678);
        send(40'h8_123456780);
        chk("t6_origin_not_done", done, 0);
        expect_move(2'b10, 2'd1);
        send(40'h7_123456708);
        expect_move(2'b11, 2'd2);
        send(40'h8_123456780);
        expect_move(2'b10, 2'd3);
        send(40'h7_123456708);
        send(40'h8_123456780);
        chk("t6_error", error, 1);
        chk("t6_err_code", err_code, 4);
        chk("t6_count", move_count, 3);
        chk("t6_mv_valid", mv_valid, 0);

        // 6b: asynchronous reset while a move is pending
        start_path(1'b1, 40'h0_012345678);
        mv_ready = 1'b0;
        send(40'h8_123456780);
        send(40'h7_123456708);
        chk("t6b_pending", mv_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6b_async_mv_valid", mv_valid, 0);
        chk("t6b_async_count", move_count, 0);
        chk("t6b_async_ready", in_ready, 0);
        mv_ready = 1'b1;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(3);
        chk("t6b_no_move", mv_valid, 0);

        chk("sb_empty", exp_code_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
